// File: rtl/pcm_fifo_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : pcm_fifo_packer_if
// Brief    : PCM sample input and byte-wide TX FIFO write port for the packer.
// Revision : 1.0
// ============================================================================
interface pcm_fifo_packer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  pcm_valid_i;
    logic [DATA_WIDTH-1:0] pcm_data_i;
    logic                  fifo_full_i;
    logic                  fifo_wr_en_o;
    logic [7:0]            fifo_data_o;

    // Environment side: sample source plus FIFO status, observes FIFO writes.
    modport master (
        output pcm_valid_i,
        output pcm_data_i,
        output fifo_full_i,
        input  fifo_wr_en_o,
        input  fifo_data_o
    );

    modport slave (
        input  pcm_valid_i,
        input  pcm_data_i,
        input  fifo_full_i,
        output fifo_wr_en_o,
        output fifo_data_o
    );
endinterface
`default_nettype wire

// File: rtl/pcm_fifo_packer.sv
`default_nettype none
// ============================================================================
// Module   : pcm_fifo_packer
// Brief    : Byte-serialises PCM samples into the TX FIFO with periodic sync
//            headers, a one-sample pending slot and drop statistics.
// Revision : 1.0
// ============================================================================
module pcm_fifo_packer #(
    parameter int         DATA_WIDTH     = 16,
    parameter int         SYNC_INTERVAL  = 256,
    parameter logic [7:0] SYNC_BYTE0     = 8'hA5,
    parameter logic [7:0] SYNC_BYTE1     = 8'h5A,
    parameter int         DROP_CNT_WIDTH = 16
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      enable_i,
    input  wire logic                      clear_stats_i,
    pcm_fifo_packer_if.slave               bus,
    output logic                           busy_o,
    output logic                           overflow_o,
    output logic [DROP_CNT_WIDTH-1:0]      drop_count_o
);

    localparam int c_CNT_W = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((SYNC_INTERVAL > 0) ? (SYNC_INTERVAL - 1) : 0);
    localparam logic c_HDR_EN = (SYNC_INTERVAL != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC0 = 3'd1,
        S_SYNC1 = 3'd2,
        S_SEQ   = 3'd3,
        S_LSB   = 3'd4,
        S_MSB   = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [DATA_WIDTH-1:0]     r_work;
    logic [DATA_WIDTH-1:0]     r_pend_data;
    logic                      r_pend_valid;
    logic [c_CNT_W-1:0]        r_sample_cnt;
    logic [c_CNT_W-1:0]        w_cnt_inc;
    logic [7:0]                r_seq;
    logic                      r_overflow;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    logic       w_wr;
    logic [7:0] w_byte;
    logic       w_load;
    logic       w_hdr_now;
    logic       w_hdr_next;
    logic       w_capture;
    logic       w_drop;

    assign w_cnt_inc  = (r_sample_cnt == c_CNT_LAST) ? '0 : r_sample_cnt + c_CNT_W'(1);
    assign w_hdr_now  = c_HDR_EN && (r_sample_cnt == '0);
    // A sample loaded straight out of MSB sees the counter as it will be after this write.
    assign w_hdr_next = c_HDR_EN && (w_cnt_inc == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_byte      = 8'h00;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_hdr_now ? S_SYNC0 : S_LSB;
                end
            end
            S_SYNC0: begin
                w_byte = SYNC_BYTE0;
                w_wr   = ~bus.fifo_full_i;
                if (w_wr) w_state_nxt = S_SYNC1;
            end
            S_SYNC1: begin
                w_byte = SYNC_BYTE1;
                w_wr   = ~bus.fifo_full_i;
                if (w_wr) w_state_nxt = S_SEQ;
            end
            S_SEQ: begin
                w_byte = r_seq;
                w_wr   = ~bus.fifo_full_i;
                if (w_wr) w_state_nxt = S_LSB;
            end
            S_LSB: begin
                w_byte = r_work[7:0];
                w_wr   = ~bus.fifo_full_i;
                if (w_wr) w_state_nxt = S_MSB;
            end
            S_MSB: begin
                w_byte = r_work[15:8];
                w_wr   = ~bus.fifo_full_i;
                if (w_wr) begin
                    if (r_pend_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = w_hdr_next ? S_SYNC0 : S_LSB;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_capture = bus.pcm_valid_i & enable_i;
    // The slot frees up in the same cycle it is loaded, so that capture is not a drop.
    assign w_drop    = w_capture & r_pend_valid & ~w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_work       <= '0;
            r_pend_data  <= '0;
            r_pend_valid <= 1'b0;
            r_sample_cnt <= '0;
            r_seq        <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) r_work <= r_pend_data;
            if (w_capture && (!r_pend_valid || w_load)) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= bus.pcm_data_i;
            end else if (w_load) begin
                r_pend_valid <= 1'b0;
            end
            if (r_state == S_SEQ && w_wr) r_seq <= r_seq + 8'd1;
            if (r_state == S_MSB && w_wr) r_sample_cnt <= w_cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_stats_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
        end
    end

    assign bus.fifo_wr_en_o = w_wr;
    assign bus.fifo_data_o  = w_byte;
    assign busy_o           = (r_state != S_IDLE) | r_pend_valid;
    assign overflow_o       = r_overflow;
    assign drop_count_o     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcm_fifo_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcm_fifo_packer
// Brief    : Directed and randomized bench for pcm_fifo_packer against a
//            byte-stream reference model.
// Revision : 1.0
// ============================================================================
module tb_pcm_fifo_packer;

    localparam int SI = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear_stats = 1'b0;
    logic        busy;
    logic        overflow;
    logic [15:0] drop_count;

    pcm_fifo_packer_if #(.DATA_WIDTH(16)) bus ();

    pcm_fifo_packer #(
        .DATA_WIDTH    (16),
        .SYNC_INTERVAL (SI),
        .SYNC_BYTE0    (8'hA5),
        .SYNC_BYTE1    (8'h5A),
        .DROP_CNT_WIDTH(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .clear_stats_i(clear_stats),
        .bus          (bus),
        .busy_o       (busy),
        .overflow_o   (overflow),
        .drop_count_o (drop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the expected byte stream, with the last byte of each
    // sample tagged so samples still owed to the FIFO can be counted.
    logic [7:0]  m_bytes[$];
    bit          m_last[$];
    int          m_cnt = 0;
    int          m_samples = 0;
    logic [7:0]  m_seq = 8'h00;
    logic        m_ovf = 1'b0;
    logic [15:0] m_drop = 16'h0;
    int          wr_total = 0;
    int          stall = 0;
    logic [7:0]  pop_b;
    bit          pop_l;
    bit          drop_now;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_wr_en", bus.fifo_wr_en_o, 0);
            check("rst_data", bus.fifo_data_o, 0);
            check("rst_busy", busy, 0);
            check("rst_overflow", overflow, 0);
            check("rst_drop_count", drop_count, 0);
            m_bytes.delete();
            m_last.delete();
            m_cnt = 0;
            m_samples = 0;
            m_seq = 8'h00;
            m_ovf = 1'b0;
            m_drop = 16'h0;
            stall = 0;
        end else begin
            check("busy", busy, (m_cnt != 0));
            check("overflow", overflow, m_ovf);
            check("drop_count", drop_count, m_drop);
            if (bus.fifo_full_i) check("wr_while_full", bus.fifo_wr_en_o, 0);
            if (m_cnt != 0 && !bus.fifo_full_i && !bus.fifo_wr_en_o) stall++;
            else stall = 0;
            if (m_cnt != 0) check("stall_cycles_le1", (stall <= 1), 1);
            if (bus.fifo_wr_en_o) begin
                wr_total++;
                if (m_bytes.size() == 0) begin
                    check("unexpected_write", bus.fifo_data_o, 9'h100);
                end else begin
                    pop_b = m_bytes.pop_front();
                    pop_l = m_last.pop_front();
                    check("stream_byte", bus.fifo_data_o, pop_b);
                    if (pop_l) m_cnt--;
                end
            end
            drop_now = 1'b0;
            if (bus.pcm_valid_i && enable) begin
                if (m_cnt < 2) begin
                    if (SI != 0 && (m_samples % SI) == 0) begin
                        m_bytes.push_back(8'hA5); m_last.push_back(1'b0);
                        m_bytes.push_back(8'h5A); m_last.push_back(1'b0);
                        m_bytes.push_back(m_seq); m_last.push_back(1'b0);
                        m_seq = m_seq + 8'd1;
                    end
                    m_bytes.push_back(bus.pcm_data_i[7:0]);  m_last.push_back(1'b0);
                    m_bytes.push_back(bus.pcm_data_i[15:8]); m_last.push_back(1'b1);
                    m_samples++;
                    m_cnt++;
                end else begin
                    drop_now = 1'b1;
                end
            end
            if (clear_stats) begin
                m_ovf = 1'b0;
                m_drop = 16'h0;
            end else if (drop_now) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        bus.pcm_valid_i = 1'b1;
        bus.pcm_data_i  = d;
        step();
        bus.pcm_valid_i = 1'b0;
    endtask

    task automatic expect_cycle(input string name, input logic en, input logic [7:0] d);
        @(negedge clk);
        check({name, "_wr_en"}, bus.fifo_wr_en_o, en);
        if (en) check({name, "_data"}, bus.fifo_data_o, d);
        step();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int base;

    initial begin
        bus.pcm_valid_i = 1'b0;
        bus.pcm_data_i  = 16'h0;
        bus.fifo_full_i = 1'b0;
        step();
        step();
        step();
        rst = 1'b0;
        enable = 1'b1;
        step();

        // Header plus first sample, then a header-less second sample.
        send(16'h1234);
        expect_cycle("t1_n1", 1'b0, 8'h00);
        expect_cycle("t1_sync0", 1'b1, 8'hA5);
        expect_cycle("t1_sync1", 1'b1, 8'h5A);
        expect_cycle("t1_seq", 1'b1, 8'h00);
        expect_cycle("t1_lsb", 1'b1, 8'h34);
        expect_cycle("t1_msb", 1'b1, 8'h12);
        expect_cycle("t1_idle", 1'b0, 8'h00);
        send(16'hBEEF);
        expect_cycle("t1b_n1", 1'b0, 8'h00);
        expect_cycle("t1b_lsb", 1'b1, 8'hEF);
        expect_cycle("t1b_msb", 1'b1, 8'hBE);
        expect_cycle("t1b_idle", 1'b0, 8'h00);

        // Nine spaced samples: headers before samples 1, 5 and 9.
        pulse_reset();
        base = wr_total;
        for (int i = 0; i < 9; i++) begin
            send(16'(16'h0101 * (i + 1)));
            repeat (6) step();
        end
        check("t2_total_writes", wr_total - base, 27);

        // Back-pressure while in LSB.
        pulse_reset();
        send(16'h1234);
        repeat (8) step();
        send(16'hBEEF);
        step();
        bus.fifo_full_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_full_wr_en", bus.fifo_wr_en_o, 0);
            check("t3_full_data", bus.fifo_data_o, 8'hEF);
            step();
        end
        bus.fifo_full_i = 1'b0;
        expect_cycle("t3_lsb", 1'b1, 8'hEF);
        expect_cycle("t3_msb", 1'b1, 8'hBE);
        expect_cycle("t3_idle", 1'b0, 8'h00);

        // Full during header: work + pending occupied, third sample dropped.
        pulse_reset();
        bus.fifo_full_i = 1'b1;
        base = wr_total;
        send(16'h1111);
        step();
        send(16'h2222);
        step();
        send(16'h3333);
        @(negedge clk);
        check("t4_overflow", overflow, 1);
        check("t4_drop_count", drop_count, 1);
        step();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        @(negedge clk);
        check("t4_overflow_cleared", overflow, 0);
        check("t4_drop_cleared", drop_count, 0);
        step();
        bus.fifo_full_i = 1'b0;
        repeat (12) step();
        check("t4_total_writes", wr_total - base, 7);

        // Asynchronous reset mid-header.
        pulse_reset();
        send(16'h5555);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("t5_rst_wr_en", bus.fifo_wr_en_o, 0);
        check("t5_rst_data", bus.fifo_data_o, 0);
        check("t5_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        send(16'h6677);
        expect_cycle("t5_n1", 1'b0, 8'h00);
        expect_cycle("t5_sync0", 1'b1, 8'hA5);
        expect_cycle("t5_sync1", 1'b1, 8'h5A);
        expect_cycle("t5_seq", 1'b1, 8'h00);
        expect_cycle("t5_lsb", 1'b1, 8'h77);
        expect_cycle("t5_msb", 1'b1, 8'h66);

        // Disabled capture, then disable in the middle of a frame.
        pulse_reset();
        enable = 1'b0;
        base = wr_total;
        for (int i = 0; i < 5; i++) begin
            send(16'hC0DE);
            step();
        end
        repeat (3) step();
        check("t6_disabled_writes", wr_total - base, 0);
        check("t6_disabled_drops", drop_count, 0);
        enable = 1'b1;
        send(16'h7788);
        enable = 1'b0;
        send(16'h9999);
        repeat (8) step();
        check("t6_frame_writes", wr_total - base, 5);
        enable = 1'b1;

        // Randomized traffic against the model.
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.pcm_valid_i = ($urandom_range(0, 99) < 35);
            bus.pcm_data_i  = 16'($urandom);
            bus.fifo_full_i = ($urandom_range(0, 99) < 25);
            enable          = ($urandom_range(0, 99) < 92);
            clear_stats     = ($urandom_range(0, 99) < 2);
            step();
        end
        bus.pcm_valid_i = 1'b0;
        bus.fifo_full_i = 1'b0;
        clear_stats = 1'b0;
        for (int i = 0; i < 40 && busy; i++) step();
        check("drain_busy", busy, 0);
        @(negedge clk);
        #1;
        check("drain_queue_empty", m_bytes.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
